operand_collector: RTL
======================

# operand_collector

Multi-entry, multi-source operand collection buffer between issue and execution. Accepts issued instructions with up to SRC register/immediate/PC/ROB-tagged operands, reads GPR/FPR at issue, then snoops WB_PORTS writeback/commit buses to fill pending ROB-tagged operands. It releases instructions to the execution unit in issue order once every operand is valid, under a busy/enable handshake.

## Interface
- DATA, `DataWidth: operand width
- ROB_DEPTH, `RobDepth: ROB entries; ROB = $clog2(ROB_DEPTH)
- SRC, 3: operands per instruction (1..4)
- WB_PORTS, 2: snooped result buses (writeback and commit each count as one)
- DEPTH, 4: buffer entries (power of two, ≥2)
- ADDR, `AddrWidth: PC width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- issue_e_  in  1  issue valid, active-low
- issue_rs  in  SRC×RegFile_t  operand descriptors (regtype, addr)
- issue_imm  in  ImmData_t  immediate (data, size, shift, sign)
- issue_pc  in  ADDR  instruction PC
- issue_busy  out  1  buffer full; issue ignored while high
- gpr_addr, fpr_addr  out  SRC×5  combinational register-file read addresses (0 when unused)
- gpr_data, fpr_data  in  SRC×DATA  same-cycle read data
- wb_e_  in  WB_PORTS  result valid per port, active-low
- wb_rob_id  in  WB_PORTS×ROB  result tag
- wb_data  in  WB_PORTS×DATA  result value
- out_e_  out  1  head entry complete, active-low
- out_data  out  SRC×DATA  head operands
- out_busy  in  1  execution unit stall

## Operation
- Entry state: valid, per-source ready bit, per-source ROB tag, per-source data. Circular FIFO, head/tail pointers of $clog2(DEPTH) bits plus one wrap bit.
- Issue accepted when !issue_e_ && !issue_busy && !flush; writes at tail.
- Per-source capture at issue by regtype: GPR → gpr_data, ready; FPR → fpr_data, ready; IMM → imm_gen output, ready; PC → zero-extended issue_pc, ready; ROB → ready only if a wb port matches addr[ROB-1:0] this cycle (data from that port), else pending with tag; other → 0, ready.
- Immediate: size5 → 5-bit extend; size5_12 → raw data; size12 → 12-bit extend, optional <<1; size20 → 20-bit extend with <<1 or <<12; sign bit selects sign/zero extension.
- Wakeup: every cycle, each valid pending source compares its tag to all asserted wb ports; match → latch data, set ready. Multiple ports matching one tag: lowest port index wins.
- Output: out_e_ low iff head valid and all sources ready. Pop when !out_e_ && !out_busy.
- issue_busy = (count == DEPTH); a pop in the same cycle does not free the slot for that cycle's issue.
- Flush: all valid bits clear, pointers to 0 next cycle; concurrent issue, wakeup and pop discarded.

## Timing
- Reset: all entries invalid, pointers 0, out_e_ = 1, out_data = 0, issue_busy = 0.
- Issue cycle N with all sources ready → out_e_ low at N+1 (empty buffer).
- Pending source woken at cycle M → eligible at M+1.
- Wakeup coinciding with the issue cycle of the matching tag: captured (no lost result).
- Wakeup coinciding with pop of the matching entry: irrelevant (entry already complete).
- out_data and out_e_ held stable while out_busy is high.
- Pointer wrap: DEPTH consecutive issues/pops wrap without loss; full/empty distinguished by wrap bit.
- Reset or flush mid-stall: buffer empties next cycle regardless of out_busy.

## Structure
- Shared package: RegFile_t, ImmData_t, regtype/imm enums (existing), new OpEntry_t (valid, ready[SRC], tag[SRC], data[SRC]).
- Sub-module imm_gen: combinational immediate extension/shift, reused by other issue logic.

## Test plan
- Issue GPR x5=0x1234, IMM size12 sign 0xFFF, PC 0x100 → next cycle out_e_=0, out_data={0x1234, 0xFFFFFFFF, 0x100}.
- Issue ROB tag 7 pending; wb port1 tag 7 data 0xAA two cycles later → out_e_ low the cycle after wb, data 0xAA.
- Issue ROB tag 3 with wb port0 tag 3 data 0x55 same cycle → out_e_ low next cycle with 0x55.
- Fill DEPTH=4 entries with out_busy=1 → issue_busy=1, 5th issue dropped; release → four outputs in order, pointers wrap.
- Head pending, second entry ready → out_e_ stays high (in-order), both drain after head wakeup.
- Flush and reset asserted with 3 entries and concurrent issue → next cycle out_e_=1, issue_busy=0, count 0.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// Shared issue-stage types: register/immediate descriptors and the operand
// collector entry layout.
package operand_collector_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ROB_DEPTH  = 16;
    localparam int ROB_W      = $clog2(ROB_DEPTH);
    localparam int ADDR_WIDTH = 32;
    localparam int SRC_N      = 3;
    localparam int REG_W      = 5;
    localparam int IMM_W      = 20;

    typedef enum logic [2:0] {
        RT_NONE, RT_GPR, RT_FPR, RT_IMM, RT_PC, RT_ROB
    } regtype_t;

    typedef enum logic [1:0] {
        IMM_SIZE5, IMM_SIZE5_12, IMM_SIZE12, IMM_SIZE20
    } imm_size_t;

    typedef enum logic [1:0] {
        SHIFT_NONE, SHIFT_1, SHIFT_12
    } imm_shift_t;

    // For RT_ROB the low ROB_W bits of addr carry the ROB tag.
    typedef struct packed {
        regtype_t          regtype;
        logic [REG_W-1:0]  addr;
    } RegFile_t;

    typedef struct packed {
        logic [IMM_W-1:0]  data;
        imm_size_t         size;
        imm_shift_t        shift;
        logic              sign;
    } ImmData_t;

    typedef struct packed {
        logic                                 valid;
        logic [SRC_N-1:0]                     ready;
        logic [SRC_N-1:0][ROB_W-1:0]          tag;
        logic [SRC_N-1:0][DATA_WIDTH-1:0]     data;
    } OpEntry_t;

endpackage

// File: rtl/operand_collector_imm_gen.sv
// Combinational immediate extension and shift.
module imm_gen
    import operand_collector_pkg::*;
#(
    parameter int DATA = DATA_WIDTH
) (
    input  ImmData_t          imm,
    output logic [DATA-1:0]   value
);

    logic [DATA-1:0] ext;

    always_comb begin
        ext   = '0;
        value = '0;
        unique case (imm.size)
            IMM_SIZE5: begin
                ext   = imm.sign ? {{(DATA-5){imm.data[4]}}, imm.data[4:0]} : DATA'(imm.data[4:0]);
                value = ext;
            end
            IMM_SIZE5_12: begin
                ext   = DATA'(imm.data);
                value = ext;
            end
            IMM_SIZE12: begin
                ext   = imm.sign ? {{(DATA-12){imm.data[11]}}, imm.data[11:0]} : DATA'(imm.data[11:0]);
                value = (imm.shift == SHIFT_1) ? (ext << 1) : ext;
            end
            IMM_SIZE20: begin
                ext   = imm.sign ? {{(DATA-20){imm.data[19]}}, imm.data[19:0]} : DATA'(imm.data[19:0]);
                value = (imm.shift == SHIFT_12) ? (ext << 12) :
                        (imm.shift == SHIFT_1)  ? (ext << 1)  : ext;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_collector.sv
// In-order operand collection buffer: captures operands at issue, snoops
// result buses for pending ROB tags, releases the head once complete.
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WB_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 issue_e_,
    input  RegFile_t [SRC_N-1:0]                 issue_rs,
    input  ImmData_t                             issue_imm,
    input  logic [ADDR_WIDTH-1:0]                issue_pc,
    output logic                                 issue_busy,
    output logic [SRC_N-1:0][REG_W-1:0]          gpr_addr,
    output logic [SRC_N-1:0][REG_W-1:0]          fpr_addr,
    input  logic [SRC_N-1:0][DATA_WIDTH-1:0]     gpr_data,
    input  logic [SRC_N-1:0][DATA_WIDTH-1:0]     fpr_data,
    input  logic [WB_PORTS-1:0]                  wb_e_,
    input  logic [WB_PORTS-1:0][ROB_W-1:0]       wb_rob_id,
    input  logic [WB_PORTS-1:0][DATA_WIDTH-1:0]  wb_data,
    output logic                                 out_e_,
    output logic [SRC_N-1:0][DATA_WIDTH-1:0]     out_data,
    input  logic                                 out_busy
);

    localparam int PTR_W = $clog2(DEPTH);

    OpEntry_t             entries_q [DEPTH];
    OpEntry_t             entries_d [DEPTH];
    logic [PTR_W:0]       head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]     head_idx, tail_idx;
    logic [DATA_WIDTH-1:0] imm_val;
    OpEntry_t             new_ent;
    logic                 head_rdy, push, pop;

    imm_gen #(.DATA(DATA_WIDTH)) u_imm_gen (.imm(issue_imm), .value(imm_val));

    assign head_idx   = head_q[PTR_W-1:0];
    assign tail_idx   = tail_q[PTR_W-1:0];
    // Same index with differing wrap bits means the ring is full.
    assign issue_busy = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);
    assign head_rdy   = entries_q[head_idx].valid && (&entries_q[head_idx].ready);
    assign out_e_     = !head_rdy;
    assign out_data   = entries_q[head_idx].valid ? entries_q[head_idx].data : '0;
    assign push       = !issue_e_ && !issue_busy && !flush;
    assign pop        = head_rdy && !out_busy && !flush;

    always_comb begin
        for (int s = 0; s < SRC_N; s++) begin
            gpr_addr[s] = (issue_rs[s].regtype == RT_GPR) ? issue_rs[s].addr : '0;
            fpr_addr[s] = (issue_rs[s].regtype == RT_FPR) ? issue_rs[s].addr : '0;
        end
    end

    // Descending port scan so the lowest matching port is the final writer.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        for (int s = 0; s < SRC_N; s++) begin
            new_ent.ready[s] = 1'b1;
            case (issue_rs[s].regtype)
                RT_GPR: new_ent.data[s] = gpr_data[s];
                RT_FPR: new_ent.data[s] = fpr_data[s];
                RT_IMM: new_ent.data[s] = imm_val;
                RT_PC:  new_ent.data[s] = DATA_WIDTH'(issue_pc);
                RT_ROB: begin
                    new_ent.tag[s]   = issue_rs[s].addr[ROB_W-1:0];
                    new_ent.ready[s] = 1'b0;
                    for (int p = WB_PORTS-1; p >= 0; p--) begin
                        if (!wb_e_[p] && wb_rob_id[p] == issue_rs[s].addr[ROB_W-1:0]) begin
                            new_ent.ready[s] = 1'b1;
                            new_ent.data[s]  = wb_data[p];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < SRC_N; s++) begin
                if (entries_q[e].valid && !entries_q[e].ready[s]) begin
                    for (int p = WB_PORTS-1; p >= 0; p--) begin
                        if (!wb_e_[p] && wb_rob_id[p] == entries_q[e].tag[s]) begin
                            entries_d[e].ready[s] = 1'b1;
                            entries_d[e].data[s]  = wb_data[p];
                        end
                    end
                end
            end
        end
        if (pop) begin
            entries_d[head_idx].valid = 1'b0;
            head_d = head_q + (PTR_W+1)'(1);
        end
        if (push) begin
            entries_d[tail_idx] = new_ent;
            tail_d = tail_q + (PTR_W+1)'(1);
        end
        if (flush) begin
            for (int e = 0; e < DEPTH; e++) entries_d[e].valid = 1'b0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

endmodule
